// File: rtl/fx_pkg.sv
// ---------------------------------------------------------------------------
// fx_pkg -- types and constants shared by the f(x) batch scheduler.
//   state_e       : scheduler FSM states
//   fifo_entry_t  : one buffered input element {last flag, x}
//   FP_ZERO       : IEEE-754 single-precision +0.0
// ---------------------------------------------------------------------------
package fx_pkg;

    localparam int          FP_W    = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_FX,
        ACC,
        DONE
    } state_e;

    typedef struct packed {
        logic            last;
        logic [FP_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/fx_sync_fifo.sv
// ---------------------------------------------------------------------------
// fx_sync_fifo -- single-clock FIFO with registered full/empty flags.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en_i       : global enable; low freezes pointers, count and storage
//   push_i     : write wdata_i (ignored while full)
//   pop_i      : drop the head entry (ignored while empty)
//   wdata_i    : write data
//   rdata_o    : head entry, valid while empty_o is low
//   full_o     : registered; never depends on a pop in the same cycle
//   empty_o    : registered
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fx_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = en_i & push_i & ~full_q;
    assign do_pop  = en_i & pop_i & ~empty_q;

    always_comb begin
        // NOTE: default assigned first so every path drives count_d; no latch.
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: storage is not reset; the empty flag keeps stale words unread.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/fx_batch_sched.sv
// ---------------------------------------------------------------------------
// fx_batch_sched -- computes sum(f(x)) over batches of IEEE-754 singles using
// an external f(x) evaluator and an external fixed-latency fp adder.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   clk_en             : global enable; low freezes everything
//   x_valid/x_data/x_last/x_ready : input element stream, x_last ends a batch
//   fx_start/fx_x      : evaluator request (one at a time), fx_x held to done
//   fx_done/fx_result  : evaluator completion
//   add_a/add_b/add_q  : adder operands (zero outside ACC) and result
//   sum/sum_valid      : batch sum with a one-cycle strobe
//   busy               : FSM not idle or elements still buffered
// ---------------------------------------------------------------------------
module fx_batch_sched
    import fx_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        x_valid,
    input  logic [31:0] x_data,
    input  logic        x_last,
    output logic        x_ready,
    output logic        fx_start,
    output logic [31:0] fx_x,
    input  logic        fx_done,
    input  logic [31:0] fx_result,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_q,
    output logic [31:0] sum,
    output logic        sum_valid,
    output logic        busy
);

    localparam int          CW       = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LAT);
    localparam logic [CW-1:0] CNT_ONE  = 1;

    state_e        state_q;
    logic [31:0]   acc_q, res_q, fx_x_q, sum_q;
    logic          cur_last_q, fx_start_q, sum_valid_q;
    logic [CW-1:0] cnt_q;

    fifo_entry_t   fifo_wdata, fifo_rdata;
    logic          fifo_full, fifo_empty, fifo_pop;

    assign fifo_wdata = {x_last, x_data};
    assign fifo_pop   = (state_q == ISSUE);

    fx_sync_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .en_i    (clk_en),
        .push_i  (x_valid),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= FP_ZERO;
            res_q       <= FP_ZERO;
            fx_x_q      <= FP_ZERO;
            sum_q       <= FP_ZERO;
            cur_last_q  <= 1'b0;
            fx_start_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (clk_en) begin
            fx_start_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    acc_q <= FP_ZERO;
                    if (!fifo_empty) state_q <= ISSUE;
                end
                ISSUE: begin
                    if (!fifo_empty) begin
                        fx_x_q     <= fifo_rdata.data;
                        cur_last_q <= fifo_rdata.last;
                        fx_start_q <= 1'b1;
                        state_q    <= WAIT_FX;
                    end
                end
                WAIT_FX: begin
                    if (fx_done) begin
                        res_q   <= fx_result;
                        cnt_q   <= '0;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    // Operands are steady from the first ACC cycle, so the
                    // adder output is valid once the counter reaches ADD_LAT.
                    if (cnt_q == CNT_LAST) begin
                        acc_q   <= add_q;
                        state_q <= cur_last_q ? DONE : ISSUE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    sum_q       <= acc_q;
                    sum_valid_q <= 1'b1;
                    acc_q       <= FP_ZERO;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are held while disabled and masked at the output, so a pulse
    // that lands on a stalled cycle is delivered on the next enabled one.
    assign fx_start  = fx_start_q & clk_en;
    assign sum_valid = sum_valid_q & clk_en;

    assign add_a   = (state_q == ACC) ? acc_q : FP_ZERO;
    assign add_b   = (state_q == ACC) ? res_q : FP_ZERO;
    assign fx_x    = fx_x_q;
    assign sum     = sum_q;
    assign x_ready = ~fifo_full;
    assign busy    = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_fx_batch_sched.sv
module tb_fx_batch_sched;

    localparam int DEPTH   = 4;
    localparam int ADD_LAT = 3;
    localparam int FX_LAT  = 5;
    localparam int TMO     = 2000;

    logic        clk = 1'b0, reset = 1'b1, clk_en = 1'b1;
    logic        x_valid = 1'b0, x_last = 1'b0;
    logic [31:0] x_data = 32'h0;
    logic        x_ready, fx_start, sum_valid, busy;
    logic [31:0] fx_x, add_a, add_b, add_q, sum;
    logic        fx_done = 1'b0;
    logic [31:0] fx_result = 32'h0;

    int n_vec  = 0;
    int n_miss = 0;
    int n_start = 0;
    int n_sv    = 0;

    logic [31:0] sb [$];        // expected batch sums
    logic [31:0] res_fifo [$];  // evaluator results; empty => f(x) = x

    bit          pending = 1'b0, stall_fx = 1'b0, aborted = 1'b0;
    int          dly = 0;
    logic [31:0] x_cap = 32'h0;
    logic [31:0] add_pipe [ADD_LAT];

    typedef struct {
        logic [31:0] x;
        logic        last;
        logic [31:0] res;
        logic [31:0] exp_sum;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    fx_batch_sched #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .x_valid(x_valid), .x_data(x_data), .x_last(x_last), .x_ready(x_ready),
        .fx_start(fx_start), .fx_x(fx_x), .fx_done(fx_done), .fx_result(fx_result),
        .add_a(add_a), .add_b(add_b), .add_q(add_q),
        .sum(sum), .sum_valid(sum_valid), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Exact for the small values used here: single <-> double by field remap.
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'h0) d = {b[31], 63'h0};
        else d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    // External adder: ADD_LAT-stage pipeline, not gated by clk_en.
    initial for (int i = 0; i < ADD_LAT; i++) add_pipe[i] = 32'h0;
    always @(posedge clk) begin
        add_pipe[0] <= r2sp(sp2r(add_a) + sp2r(add_b));
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_q = add_pipe[ADD_LAT-1];

    // External evaluator: answers FX_LAT cycles after fx_start unless stalled.
    always @(posedge clk) begin : eval_model
        logic [31:0] r;
        fx_done <= 1'b0;
        if (reset) aborted <= 1'b1;
        if (fx_start) begin
            pending <= 1'b1;
            dly     <= FX_LAT;
            x_cap   <= fx_x;
            aborted <= 1'b0;
        end else if (pending && !stall_fx) begin
            if (dly <= 1) begin
                r = (res_fifo.size() > 0) ? res_fifo.pop_front() : fx_x;
                fx_done   <= 1'b1;
                fx_result <= r;
                pending   <= 1'b0;
                if (!aborted) check("fx_x_held", fx_x, x_cap);
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Output monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (fx_start) begin
            n_start++;
            check("fx_start_one_in_flight", 32'(pending), 32'd0);
        end
        if (sum_valid) begin
            n_sv++;
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_sum_valid: got sum %h, expected no strobe", sum);
            end else begin
                check("batch_sum", sum, sb.pop_front());
            end
        end
    end

    task automatic push(input logic [31:0] x, input logic last, output int waited);
        @(negedge clk);
        x_valid = 1'b1;
        x_data  = x;
        x_last  = last;
        waited  = 0;
        while (!(x_ready && clk_en) && waited < TMO) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= TMO) begin
            n_vec++;
            n_miss++;
            $display("FAIL push_timeout: x_ready stayed %b, required 1", x_ready);
        end
        @(posedge clk);
        #1 x_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: busy=%b pending sums=%0d, required idle", name, busy, sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_ready"},   32'(x_ready),   32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_fx_start"},  32'(fx_start),  32'd0);
        check({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_fx_x"},      fx_x,  32'h0);
        check({tag, "_sum"},       sum,   32'h0);
        check({tag, "_add_a"},     add_a, 32'h0);
        check({tag, "_add_b"},     add_b, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, w5, s0, sv0, n;
        bit bad;

        vecs[0] = '{32'h3F800000, 1'b1, 32'h40000000, 32'h40000000};
        vecs[1] = '{32'h3F800000, 1'b0, 32'h3F800000, 32'h0};
        vecs[2] = '{32'h3F800000, 1'b0, 32'h3F800000, 32'h0};
        vecs[3] = '{32'h3F800000, 1'b1, 32'h3F800000, 32'h40400000};
        vecs[4] = '{32'h41000000, 1'b0, 32'h3F800000, 32'h0};
        vecs[5] = '{32'h41100000, 1'b1, 32'h40000000, 32'h40400000};
        vecs[6] = '{32'h41200000, 1'b0, 32'h40400000, 32'h0};
        vecs[7] = '{32'h41300000, 1'b1, 32'h40800000, 32'h40E00000};

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table: single element, batch of 3, two back-to-back batches.
        s0 = n_start;
        sv0 = n_sv;
        foreach (vecs[i]) begin
            res_fifo.push_back(vecs[i].res);
            if (vecs[i].last) sb.push_back(vecs[i].exp_sum);
            push(vecs[i].x, vecs[i].last, w);
        end
        wait_idle("table");
        check("table_fx_start_count", 32'(n_start - s0), 32'd8);
        check("table_sum_valid_count", 32'(n_sv - sv0), 32'd4);

        // FIFO fill with the evaluator stalled; identity results 1..6.
        s0 = n_start;
        stall_fx = 1'b1;
        push(32'h3F800000, 1'b0, w);
        n = 0;
        while (!pending && n < TMO) begin @(negedge clk); n++; end
        check("fill_sentinel_issued", 32'(pending), 32'd1);
        push(32'h40000000, 1'b0, w); check("fill_push2_no_wait", w, 0);
        push(32'h40400000, 1'b0, w); check("fill_push3_no_wait", w, 0);
        push(32'h40800000, 1'b0, w); check("fill_push4_no_wait", w, 0);
        push(32'h40A00000, 1'b0, w); check("fill_push5_no_wait", w, 0);
        check("fill_x_ready_low", 32'(x_ready), 32'd0);
        sb.push_back(32'h41A80000);
        fork
            push(32'h40C00000, 1'b1, w5);
            begin
                repeat (8) @(negedge clk);
                check("fill_still_full", 32'(x_ready), 32'd0);
                stall_fx = 1'b0;
            end
        join
        check("fill_last_was_held", 32'(w5 > 0), 32'd1);
        wait_idle("fill");
        check("fill_fx_start_count", 32'(n_start - s0), 32'd6);

        // clk_en low for 10 cycles in the first ACC; pushes must be ignored.
        res_fifo.push_back(32'h3F800000);
        res_fifo.push_back(32'h40000000);
        sb.push_back(32'h40400000);
        push(32'h40800000, 1'b0, w);
        push(32'h40A00000, 1'b1, w);
        n = 0;
        while (add_b == 32'h0 && n < TMO) begin @(negedge clk); n++; end
        clk_en  = 1'b0;
        x_valid = 1'b1;
        x_data  = 32'h41100000;
        x_last  = 1'b1;
        n = 1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fx_start || sum_valid || add_b != 32'h3F800000) bad = 1'b1;
            if (add_b != 32'h0) n++;
        end
        x_valid = 1'b0;
        clk_en  = 1'b1;
        @(negedge clk);
        while (add_b != 32'h0 && n < TMO) begin n++; @(negedge clk); end
        check("stall_frozen", 32'(bad), 32'd0);
        check("stall_acc_cycles", n, ADD_LAT + 11);
        check("add_a_zero_outside_acc", add_a, 32'h0);
        wait_idle("stall");

        // Reset (with clk_en low) while waiting on the evaluator.
        res_fifo.push_back(32'h40A00000);
        push(32'h3F800000, 1'b1, w);
        n = 0;
        while (!pending && n < TMO) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        clk_en = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        clk_en = 1'b1;
        check_reset_outputs("midreset");
        repeat (12) @(negedge clk);
        check("late_fx_done_ignored_busy", 32'(busy), 32'd0);
        res_fifo.push_back(32'h3F800000);
        res_fifo.push_back(32'h40000000);
        sb.push_back(32'h40400000);
        push(32'h41000000, 1'b0, w);
        push(32'h41000000, 1'b1, w);
        wait_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fx_batch_sched.md
FX_BATCH_SCHED -- requirements
Module: fx_batch_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, input FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter ADD_LAT, default 3, fixed latency in cycles of the external fp adder.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 clk_en  in  1  global enable; low freezes all state.
REQ-006 x_valid  in  1  input element offered.
REQ-007 x_data  in  32  IEEE-754 single x.
REQ-008 x_last  in  1  marks final element of a batch; qualified by x_valid.
REQ-009 x_ready  out  1  FIFO can accept this cycle.
REQ-010 fx_start  out  1  one-cycle start pulse to the f(x) evaluator.
REQ-011 fx_x  out  32  operand to evaluator; held from the start cycle until fx_done.
REQ-012 fx_done  in  1  evaluator completion pulse.
REQ-013 fx_result  in  32  evaluator result; valid while fx_done is high.
REQ-014 add_a, add_b  out  32 each  adder operands.
REQ-015 add_q  in  32  adder result, ADD_LAT cycles after the operands are applied.
REQ-016 sum  out  32  batch sum; valid with sum_valid.
REQ-017 sum_valid  out  1  one-cycle pulse per completed batch.
REQ-018 busy  out  1  high whenever state != IDLE or FIFO is non-empty.

Function
REQ-019 SHALL buffer {x_data, x_last} in a DEPTH-entry FIFO; push on x_valid && x_ready; x_ready = !full, registered, not combinationally dependent on pop (no pass-through when full).
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_FX, ACC, DONE.
REQ-021 IDLE: acc = 0; go ISSUE when FIFO non-empty.
REQ-022 ISSUE: when non-empty, pop the head, latch x into fx_x and the last flag into cur_last, assert fx_start for exactly this cycle, and go WAIT_FX; when empty, hold ISSUE with fx_start = 0.
REQ-023 WAIT_FX: on fx_done, latch fx_result into res_reg and go ACC; fx_done in any other state SHALL be ignored.
REQ-024 ACC: drive add_a = acc and add_b = res_reg constant for the whole state; a counter runs 0..ADD_LAT; at count == ADD_LAT, acc <= add_q and leave ACC.
REQ-025 ACC exit: go DONE if cur_last = 1, otherwise go ISSUE.
REQ-026 DONE: sum <= acc, assert sum_valid for one cycle, clear acc, go IDLE.
REQ-027 Outside ACC, add_a and add_b SHALL be 0x00000000.
REQ-028 Exactly one evaluator operation SHALL be in flight at a time; the block SHALL never assert fx_start while in WAIT_FX.
REQ-029 Pushes SHALL be accepted in every state, including during DONE, without loss.
REQ-030 A batch of N elements SHALL produce exactly one sum_valid, with the elements summed in arrival order.
REQ-031 clk_en = 0: state, counter, FIFO, and registers hold; fx_start and sum_valid are forced to 0; pushes are ignored.

Reset
REQ-032 On reset: state = IDLE; FIFO is emptied (pointers 0); acc, res_reg, fx_x, sum, add_a, add_b = 0; fx_start, sum_valid, cur_last = 0; x_ready = 1; busy = 0.
REQ-033 Reset mid-batch SHALL abandon the batch with no sum_valid; a late fx_done after reset SHALL be ignored (the block is in IDLE).
REQ-034 Reset SHALL take priority over clk_en.

Structure
REQ-035 The state enum typedef and the FP constants (FP_ZERO 0x00000000) SHALL live in shared package fx_pkg.
REQ-036 The FIFO SHALL be a separate sub-module, fx_sync_fifo (parameterised width and depth, with full and empty flags).
REQ-037 The evaluator and the adder SHALL be external; the block SHALL instantiate no floating-point IP.

Verification
REQ-038 Single element: push 0x3F800000 with x_last = 1; model returns 0x40000000 after 5 cycles -> one fx_start, one sum_valid, sum = 0x40000000.
REQ-039 Batch of 3 with the model returning 0x3F800000 each time -> three fx_start pulses, each after the prior fx_done; one sum_valid with sum = 0x40400000.
REQ-040 Fill the FIFO: 5 back-to-back pushes while the evaluator is stalled -> x_ready falls after the 4th; the 5th is held by the source and is accepted after the first pop; no data is lost.
REQ-041 clk_en low for 10 cycles during ACC -> add_q is sampled only after ADD_LAT enabled cycles; final sum is unchanged versus the no-stall run.
REQ-042 Reset asserted in WAIT_FX, then fx_done pulses -> no sum_valid; outputs match REQ-032; the next batch sums correctly from 0.
REQ-043 Two batches back-to-back (x_last on elements 2 and 4, results 1.0, 2.0, 3.0, 4.0) -> sums 0x40400000 then 0x40E00000.
